// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM bus arbiter: state and owner encodings,
// the full-word lane mask and the default watchdog limit.
package bus_arbiter_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    localparam logic [3:0] BYTE_SELECT_WORD = 4'b1111;
    localparam int         DEFAULT_TIMEOUT  = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for one bus transaction; flags expiry on the BUSY cycle in
// which the count would reach TIMEOUT, so a transaction lasts at most TIMEOUT cycles.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && count_reg != 8'hFF) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // Compare in 9 bits so TIMEOUT = 255 does not wrap.
    assign expired = enable && (({1'b0, count_reg} + 9'd1) == 9'(TIMEOUT));

endmodule

// File: rtl/bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the data
// stage, MEM first, holding each completed result until the pipeline advances.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipeline_advance,
    input  logic        if_read_enable,
    input  logic [31:0] if_address,
    output logic [31:0] if_data,
    output logic        if_stall,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_byte_select,
    output logic [31:0] mem_read_data,
    output logic        mem_stall,
    output logic        bus_request,
    output logic        bus_write_enable,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_select,
    input  logic        bus_ack,
    input  logic [31:0] bus_read_data,
    output logic        bus_error
);

    state_t      state_reg;
    owner_t      owner_reg;
    logic        if_done_reg;
    logic        mem_done_reg;
    logic        bus_request_reg;
    logic        bus_write_enable_reg;
    logic [31:0] bus_address_reg;
    logic [31:0] bus_write_data_reg;
    logic [3:0]  bus_byte_select_reg;
    logic [31:0] if_data_reg;
    logic [31:0] mem_read_data_reg;
    logic        bus_error_reg;

    logic mem_request;
    logic grant_mem;
    logic grant_if;
    logic busy;
    logic expired;
    logic complete;

    assign mem_request = mem_read_enable | mem_write_enable;
    assign busy        = (state_reg == STATE_BUSY);
    assign grant_mem   = !busy && mem_request && !mem_done_reg;
    assign grant_if    = !busy && !grant_mem && if_read_enable && !if_done_reg;
    // An ack on the final allowed cycle beats the watchdog.
    assign complete    = busy && (bus_ack || expired);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (grant_mem | grant_if),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg            <= STATE_IDLE;
            owner_reg            <= OWNER_IF;
            if_done_reg          <= 1'b0;
            mem_done_reg         <= 1'b0;
            bus_request_reg      <= 1'b0;
            bus_write_enable_reg <= 1'b0;
            bus_address_reg      <= '0;
            bus_write_data_reg   <= '0;
            bus_byte_select_reg  <= '0;
            if_data_reg          <= '0;
            mem_read_data_reg    <= '0;
            bus_error_reg        <= 1'b0;
        end else begin
            // Done flags set later in this block override this clear.
            if (pipeline_advance) begin
                if_done_reg  <= 1'b0;
                mem_done_reg <= 1'b0;
            end

            if (state_reg == STATE_IDLE) begin
                if (grant_mem) begin
                    owner_reg            <= OWNER_MEM;
                    bus_address_reg      <= mem_address;
                    bus_write_enable_reg <= mem_write_enable;
                    bus_write_data_reg   <= mem_write_data;
                    bus_byte_select_reg  <= mem_byte_select;
                    bus_request_reg      <= 1'b1;
                    state_reg            <= STATE_BUSY;
                end else if (grant_if) begin
                    owner_reg            <= OWNER_IF;
                    bus_address_reg      <= if_address;
                    bus_write_enable_reg <= 1'b0;
                    bus_write_data_reg   <= '0;
                    bus_byte_select_reg  <= BYTE_SELECT_WORD;
                    bus_request_reg      <= 1'b1;
                    state_reg            <= STATE_BUSY;
                end
            end else if (complete) begin
                bus_request_reg <= 1'b0;
                state_reg       <= STATE_IDLE;
                if (!bus_ack) begin
                    bus_error_reg <= 1'b1;
                end
                if (owner_reg == OWNER_IF) begin
                    if_done_reg <= 1'b1;
                    if_data_reg <= bus_ack ? bus_read_data : 32'h0;
                end else begin
                    mem_done_reg <= 1'b1;
                    // A store that completes normally leaves the load result untouched.
                    if (!bus_ack) begin
                        mem_read_data_reg <= 32'h0;
                    end else if (!bus_write_enable_reg) begin
                        mem_read_data_reg <= bus_read_data;
                    end
                end
            end
        end
    end

    assign if_stall         = reset & if_read_enable & ~if_done_reg;
    assign mem_stall        = reset & mem_request & ~mem_done_reg;
    assign if_data          = if_data_reg;
    assign mem_read_data    = mem_read_data_reg;
    assign bus_request      = bus_request_reg;
    assign bus_write_enable = bus_write_enable_reg;
    assign bus_address      = bus_address_reg;
    assign bus_write_data   = bus_write_data_reg;
    assign bus_byte_select  = bus_byte_select_reg;
    assign bus_error        = bus_error_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// request mixes checked against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        pipeline_advance;
    logic        if_read_enable;
    logic [31:0] if_address;
    logic [31:0] if_data;
    logic        if_stall;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_select;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic        bus_request;
    logic        bus_write_enable;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_select;
    logic        bus_ack;
    logic [31:0] bus_read_data;
    logic        bus_error;

    int checks = 0;
    int fails  = 0;

    // Reference state: last results the pipeline should see.
    logic [31:0] exp_if_data  = 32'h0;
    logic [31:0] exp_mem_data = 32'h0;

    typedef struct {
        bit          is_mem;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  bs;
    } txn_t;

    bus_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pipeline_advance (pipeline_advance),
        .if_read_enable   (if_read_enable),
        .if_address       (if_address),
        .if_data          (if_data),
        .if_stall         (if_stall),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_byte_select  (mem_byte_select),
        .mem_read_data    (mem_read_data),
        .mem_stall        (mem_stall),
        .bus_request      (bus_request),
        .bus_write_enable (bus_write_enable),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_select  (bus_byte_select),
        .bus_ack          (bus_ack),
        .bus_read_data    (bus_read_data),
        .bus_error        (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic idle_inputs();
        if_read_enable   = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        pipeline_advance = 1'b0;
        bus_ack          = 1'b0;
    endtask

    task automatic advance();
        idle_inputs();
        pipeline_advance = 1'b1;
        @(negedge clock);
        pipeline_advance = 1'b0;
        @(negedge clock);
    endtask

    // Bus-side responder: waits (bounded) for bus_request, records the presented
    // fields, waits lat more cycles watching they stay put, then optionally acks.
    task automatic serve(input int lat, input logic [31:0] rdata, input bit do_ack,
                         output bit granted, output int waited,
                         output logic [31:0] a, output logic we,
                         output logic [31:0] wd, output logic [3:0] bs,
                         output bit held);
        granted = 1'b0;
        waited  = 0;
        held    = 1'b1;
        a = '0; we = 1'b0; wd = '0; bs = '0;
        while (!granted && waited < 20) begin
            if (bus_request === 1'b1) granted = 1'b1;
            else begin
                @(negedge clock);
                waited++;
            end
        end
        if (granted) begin
            a  = bus_address;
            we = bus_write_enable;
            wd = bus_write_data;
            bs = bus_byte_select;
            for (int i = 0; i < lat; i++) begin
                @(negedge clock);
                if (bus_request !== 1'b1 || bus_address !== a || bus_write_enable !== we ||
                    bus_write_data !== wd || bus_byte_select !== bs)
                    held = 1'b0;
            end
            if (do_ack) begin
                bus_ack       = 1'b1;
                bus_read_data = rdata;
                @(negedge clock);
                bus_ack       = 1'b0;
                bus_read_data = $urandom;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        if_read_enable  = 1'b1;
        mem_read_enable = 1'b1;
        if_address      = 32'h0;
        mem_address     = 32'h0;
        mem_write_data  = 32'h0;
        mem_byte_select = 4'b1111;
        bus_read_data   = 32'h0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus_request !== 1'b0 || bus_write_enable !== 1'b0 || bus_address !== 32'h0 ||
            bus_write_data !== 32'h0 || bus_byte_select !== 4'h0)
            begin fails++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wd=%h bs=%b, expected all 0",
                bus_request, bus_write_enable, bus_address, bus_write_data, bus_byte_select); end
        checks++;
        if (if_data !== 32'h0 || mem_read_data !== 32'h0 || bus_error !== 1'b0)
            begin fails++; $display("FAIL reset_data: got if_data=%h mem_read_data=%h err=%b, expected 0 0 0",
                if_data, mem_read_data, bus_error); end
        checks++;
        if (if_stall !== 1'b0 || mem_stall !== 1'b0)
            begin fails++; $display("FAIL reset_stall: got if_stall=%b mem_stall=%b, expected 0 0", if_stall, mem_stall); end
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        $display("test_reset done");
    endtask

    task automatic test_lone_fetch();
        bit g, held, seen;
        int w;
        logic [31:0] a, wd;
        logic we;
        logic [3:0] bs;
        if_address     = 32'h100;
        if_read_enable = 1'b1;
        #1;
        checks++;
        if (if_stall !== 1'b1)
            begin fails++; $display("FAIL fetch_stall_high: got %b, expected 1", if_stall); end
        serve(3, 32'h3C010001, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || w != 1)
            begin fails++; $display("FAIL fetch_grant_latency: got granted=%0d after %0d cycles, expected 1 cycle", g, w); end
        checks++;
        if (a !== 32'h100 || we !== 1'b0 || bs !== 4'b1111 || !held)
            begin fails++; $display("FAIL fetch_bus_fields: got addr=%h we=%b bs=%b held=%0d, expected 100 0 1111 1", a, we, bs, held); end
        checks++;
        if (if_stall !== 1'b0 || if_data !== 32'h3C010001 || bus_request !== 1'b0)
            begin fails++; $display("FAIL fetch_result: got stall=%b data=%h req=%b, expected 0 3c010001 0", if_stall, if_data, bus_request); end
        exp_if_data = 32'h3C010001;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus_request !== 1'b0 || if_stall !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen)
            begin fails++; $display("FAIL fetch_no_reissue: got extra request or stall, expected none"); end
        advance();
        $display("test_lone_fetch done");
    endtask

    task automatic test_contention_held();
        bit g, held, seen;
        int w;
        logic [31:0] a, wd, d1, d2, d3, d4;
        logic we;
        logic [3:0] bs;
        d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom;
        if_address      = 32'h100;
        if_read_enable  = 1'b1;
        mem_address     = 32'h200;
        mem_byte_select = 4'b1111;
        mem_read_enable = 1'b1;
        serve($urandom_range(0, 3), d1, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || a !== 32'h200 || we !== 1'b0 || !held)
            begin fails++; $display("FAIL contention_mem_first: got granted=%0d addr=%h we=%b, expected 1 200 0", g, a, we); end
        checks++;
        if (mem_stall !== 1'b0 || mem_read_data !== d1 || if_stall !== 1'b1)
            begin fails++; $display("FAIL contention_mem_done: got mem_stall=%b data=%h if_stall=%b, expected 0 %h 1",
                mem_stall, mem_read_data, if_stall, d1); end
        exp_mem_data = d1;
        serve($urandom_range(0, 3), d2, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || w != 1 || a !== 32'h100 || bs !== 4'b1111)
            begin fails++; $display("FAIL contention_if_second: got granted=%0d wait=%0d addr=%h bs=%b, expected 1 1 100 1111",
                g, w, a, bs); end
        checks++;
        if (if_stall !== 1'b0 || if_data !== d2 || mem_stall !== 1'b0 || mem_read_data !== d1)
            begin fails++; $display("FAIL contention_if_done: got if_stall=%b if_data=%h mem_stall=%b mem_data=%h, expected 0 %h 0 %h",
                if_stall, if_data, mem_stall, mem_read_data, d2, d1); end
        exp_if_data = d2;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (bus_request !== 1'b0 || mem_stall !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen)
            begin fails++; $display("FAIL held_no_reissue: got a reissue or stall, expected held results"); end
        // Advance with both requests still present: a fresh pair is arbitrated.
        mem_address      = 32'h300;
        if_address       = 32'h104;
        pipeline_advance = 1'b1;
        @(negedge clock);
        pipeline_advance = 1'b0;
        checks++;
        if (mem_stall !== 1'b1 || if_stall !== 1'b1)
            begin fails++; $display("FAIL held_after_advance: got mem_stall=%b if_stall=%b, expected 1 1", mem_stall, if_stall); end
        serve($urandom_range(0, 3), d3, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || a !== 32'h300 || mem_read_data !== d3)
            begin fails++; $display("FAIL held_new_mem: got granted=%0d addr=%h data=%h, expected 1 300 %h", g, a, mem_read_data, d3); end
        exp_mem_data = d3;
        serve($urandom_range(0, 3), d4, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || a !== 32'h104 || if_data !== d4)
            begin fails++; $display("FAIL held_new_if: got granted=%0d addr=%h data=%h, expected 1 104 %h", g, a, if_data, d4); end
        exp_if_data = d4;
        advance();
        $display("test_contention_held done");
    endtask

    task automatic test_store();
        bit g, held;
        int w;
        logic [31:0] a, wd;
        logic we;
        logic [3:0] bs;
        mem_address      = 32'h203;
        mem_byte_select  = 4'b1000;
        mem_write_data   = 32'hAB;
        mem_write_enable = 1'b1;
        serve(1, 32'hFFFF_0000, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || a !== 32'h203 || we !== 1'b1 || bs !== 4'b1000 || wd !== 32'hAB || !held)
            begin fails++; $display("FAIL store_bus_fields: got granted=%0d addr=%h we=%b bs=%b wd=%h, expected 1 203 1 1000 ab",
                g, a, we, bs, wd); end
        checks++;
        if (mem_stall !== 1'b0 || mem_read_data !== exp_mem_data)
            begin fails++; $display("FAIL store_no_capture: got stall=%b data=%h, expected 0 %h", mem_stall, mem_read_data, exp_mem_data); end
        advance();
        $display("test_store done");
    endtask

    task automatic test_random();
        txn_t q[$];
        txn_t t;
        bit use_if, use_mem, if_done_m, mem_done_m, g, held;
        int w, lat, bad;
        logic [31:0] a, wd, d;
        logic we;
        logic [3:0] bs;
        logic [3:0] lanes [5];
        lanes = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bad = 0;
        for (int it = 0; it < 24; it++) begin
            use_if  = 1'($urandom_range(0, 1));
            use_mem = 1'($urandom_range(0, 1));
            if (!use_if && !use_mem) use_if = 1'b1;
            if_address       = $urandom & 32'hFFFF_FFFC;
            mem_address      = $urandom;
            mem_write_data   = $urandom;
            mem_byte_select  = lanes[$urandom_range(0, 4)];
            mem_write_enable = use_mem && ($urandom_range(0, 1) == 1);
            mem_read_enable  = use_mem && !mem_write_enable;
            if_read_enable   = use_if;
            q.delete();
            if (use_mem) begin
                t.is_mem = 1'b1; t.addr = mem_address; t.we = mem_write_enable;
                t.wd = mem_write_data; t.bs = mem_byte_select;
                q.push_back(t);
            end
            if (use_if) begin
                t.is_mem = 1'b0; t.addr = if_address; t.we = 1'b0; t.wd = 32'h0; t.bs = 4'b1111;
                q.push_back(t);
            end
            if_done_m = 1'b0;
            mem_done_m = 1'b0;
            while (q.size() > 0) begin
                t   = q.pop_front();
                lat = $urandom_range(0, 3);
                d   = $urandom;
                serve(lat, d, 1'b1, g, w, a, we, wd, bs, held);
                if (t.is_mem) begin
                    mem_done_m = 1'b1;
                    if (!t.we) exp_mem_data = d;
                end else begin
                    if_done_m = 1'b1;
                    exp_if_data = d;
                end
                checks++;
                if (!g || a !== t.addr || we !== t.we || bs !== t.bs || (t.we && wd !== t.wd) || !held) begin
                    fails++; bad++;
                    $display("FAIL random_bus_%0d: got granted=%0d addr=%h we=%b bs=%b wd=%h, expected addr=%h we=%b bs=%b wd=%h",
                        it, g, a, we, bs, wd, t.addr, t.we, t.bs, t.wd);
                end
                checks++;
                if (if_data !== exp_if_data || mem_read_data !== exp_mem_data ||
                    if_stall !== (use_if && !if_done_m) || mem_stall !== (use_mem && !mem_done_m)) begin
                    fails++; bad++;
                    $display("FAIL random_result_%0d: got if=%h mem=%h if_stall=%b mem_stall=%b, expected if=%h mem=%h if_stall=%b mem_stall=%b",
                        it, if_data, mem_read_data, if_stall, mem_stall, exp_if_data, exp_mem_data,
                        use_if && !if_done_m, use_mem && !mem_done_m);
                end
            end
            advance();
        end
        $display("test_random done, %0d bad comparisons", bad);
    endtask

    task automatic test_timeout();
        bit g, held;
        int w, busy_cycles;
        logic [31:0] a, wd;
        logic we;
        logic [3:0] bs;
        if_address     = 32'h400;
        if_read_enable = 1'b1;
        serve(0, 32'h0, 1'b0, g, w, a, we, wd, bs, held);
        busy_cycles = g ? 1 : 0;
        while (bus_request === 1'b1 && busy_cycles < 20) begin
            @(negedge clock);
            if (bus_request === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 4)
            begin fails++; $display("FAIL timeout_cycles: got %0d BUSY cycles, expected 4", busy_cycles); end
        checks++;
        if (bus_error !== 1'b1 || if_stall !== 1'b0 || if_data !== 32'h0)
            begin fails++; $display("FAIL timeout_result: got err=%b stall=%b data=%h, expected 1 0 0", bus_error, if_stall, if_data); end
        exp_if_data = 32'h0;
        bus_ack       = 1'b1;
        bus_read_data = 32'hDEADBEEF;
        @(negedge clock);
        bus_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (bus_request !== 1'b0 || if_data !== 32'h0 || mem_read_data !== exp_mem_data)
            begin fails++; $display("FAIL idle_ack_ignored: got req=%b if=%h mem=%h, expected 0 0 %h", bus_request, if_data, mem_read_data, exp_mem_data); end
        advance();
        checks++;
        if (bus_error !== 1'b1)
            begin fails++; $display("FAIL error_sticky: got %b, expected 1", bus_error); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_busy();
        bit g, held;
        int w;
        logic [31:0] a, wd;
        logic we;
        logic [3:0] bs;
        mem_address     = 32'h500;
        mem_byte_select = 4'b1111;
        mem_read_enable = 1'b1;
        serve(1, 32'h0, 1'b0, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || bus_request !== 1'b1)
            begin fails++; $display("FAIL midreset_setup: got granted=%0d req=%b, expected 1 1", g, bus_request); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus_request !== 1'b0 || bus_error !== 1'b0 || mem_stall !== 1'b0 || mem_read_data !== 32'h0)
            begin fails++; $display("FAIL midreset_async: got req=%b err=%b stall=%b data=%h, expected 0 0 0 0",
                bus_request, bus_error, mem_stall, mem_read_data); end
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        exp_if_data = 32'h0;
        exp_mem_data = 32'h0;
        if_address     = 32'h600;
        if_read_enable = 1'b1;
        serve(0, 32'h1234_5678, 1'b1, g, w, a, we, wd, bs, held);
        checks++;
        if (!g || w != 1 || a !== 32'h600 || if_data !== 32'h1234_5678 || bus_error !== 1'b0)
            begin fails++; $display("FAIL midreset_recover: got granted=%0d wait=%0d addr=%h data=%h err=%b, expected 1 1 600 12345678 0",
                g, w, a, if_data, bus_error); end
        advance();
        $display("test_reset_mid_busy done");
    endtask

    initial begin
        reset            = 1'b0;
        pipeline_advance = 1'b0;
        if_read_enable   = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        bus_ack          = 1'b0;
        @(negedge clock);
        test_reset();
        test_lone_fetch();
        test_contention_held();
        test_store();
        test_random();
        test_timeout();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
